// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding-select unit for the ID stage of the 5-stage pipeline.
// Generates per-source bypass selects, load-use / RAW stalls and a saturating stall counter.
module hazard_forward_unit #(
  parameter int ADDR_W            = 5,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int ZERO_REG_HW       = 1,
  parameter int CNT_W             = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic                      flush,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic                      exe_wb_en,
  input  logic [ADDR_W-1:0]         exe_dst,
  input  logic                      exe_mem_r_en,
  input  logic                      mem_wb_en,
  input  logic [ADDR_W-1:0]         mem_dst,
  input  logic                      cnt_clr,
  output logic                      hazard_detected,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  // state   | meaning
  // IDLE    | no stall in progress; hazard follows the combinational detect terms
  // LU_WAIT | remaining cycles of a multi-cycle load-use stall, counted by r_rem
  typedef enum logic {S_IDLE, S_LU_WAIT} state_t;

  localparam logic [3:0] LU_REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_rem;
  logic [3:0]         w_rem_nxt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [NUM_SRC-1:0] w_match_exe;
  logic [NUM_SRC-1:0] w_match_mem;
  logic               w_lu;
  logic               w_raw_any;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;

    assign w_addr = src_addr[gi*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG_HW != 0) && (w_addr == '0);
    assign w_match_exe[gi] = src_valid[gi] & exe_wb_en & (w_addr == exe_dst) & ~w_zero;
    assign w_match_mem[gi] = src_valid[gi] & mem_wb_en & (w_addr == mem_dst) & ~w_zero;
    // EXE holds the youngest producer, so it wins over MEM
    assign fwd_sel[2*gi +: 2] = !fwd_en          ? 2'b00 :
                                w_match_exe[gi]  ? 2'b01 :
                                w_match_mem[gi]  ? 2'b10 : 2'b00;
  end

  assign w_lu      = exe_mem_r_en & (|w_match_exe);
  assign w_raw_any = |(w_match_exe | w_match_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fwd_en && w_lu && (LOAD_STALL_CYCLES > 1)) begin
            w_state_nxt = S_LU_WAIT;
            w_rem_nxt   = LU_REM_INIT;
          end
        end
        S_LU_WAIT: begin
          w_rem_nxt = r_rem - 4'd1;
          if (r_rem == 4'd1) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hazard_detected = 1'b0;
    if (!flush) begin
      if (r_state == S_LU_WAIT) hazard_detected = 1'b1;
      else if (fwd_en)          hazard_detected = w_lu;
      else                      hazard_detected = w_raw_any;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (hazard_detected && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: three instances (3- and 4-cycle load stalls,
// and a 1-cycle / 4-bit-counter variant) share one stimulus stream.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en;
  logic        flush;
  logic [9:0]  src_addr;
  logic [1:0]  src_valid;
  logic        exe_wb_en;
  logic [4:0]  exe_dst;
  logic        exe_mem_r_en;
  logic        mem_wb_en;
  logic [4:0]  mem_dst;
  logic        cnt_clr;

  logic        haz3, haz4, hazs;
  logic [3:0]  sel3, sel4, sels;
  logic [15:0] cnt3, cnt4;
  logic [3:0]  cnts;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .src_addr(src_addr),
    .src_valid(src_valid), .exe_wb_en(exe_wb_en), .exe_dst(exe_dst),
    .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
    .cnt_clr(cnt_clr), .hazard_detected(haz3), .fwd_sel(sel3), .stall_cnt(cnt3));

  hazard_forward_unit #(.LOAD_STALL_CYCLES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .src_addr(src_addr),
    .src_valid(src_valid), .exe_wb_en(exe_wb_en), .exe_dst(exe_dst),
    .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
    .cnt_clr(cnt_clr), .hazard_detected(haz4), .fwd_sel(sel4), .stall_cnt(cnt4));

  hazard_forward_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) u_duts (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .src_addr(src_addr),
    .src_valid(src_valid), .exe_wb_en(exe_wb_en), .exe_dst(exe_dst),
    .exe_mem_r_en(exe_mem_r_en), .mem_wb_en(mem_wb_en), .mem_dst(mem_dst),
    .cnt_clr(cnt_clr), .hazard_detected(hazs), .fwd_sel(sels), .stall_cnt(cnts));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush        = 1'b0;
    src_addr     = '0;
    src_valid    = '0;
    exe_wb_en    = 1'b0;
    exe_dst      = '0;
    exe_mem_r_en = 1'b0;
    mem_wb_en    = 1'b0;
    mem_dst      = '0;
    cnt_clr      = 1'b0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic load_use_src1(input logic [4:0] a);
    fwd_en       = 1'b1;
    src_addr     = {a, 5'd0};
    src_valid    = 2'b10;
    exe_wb_en    = 1'b1;
    exe_dst      = a;
    exe_mem_r_en = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    fwd_en = 1'b0;
    idle_inputs();
    #2;
    chk("rst_haz", 32'(haz3), 32'd0);
    chk("rst_sel", 32'(sel3), 32'd0);
    chk("rst_cnt3", 32'(cnt3), 32'd0);
    chk("rst_cnts", 32'(cnts), 32'd0);
    step();
    rst = 1'b1;
    step();

    // stall-only mode
    fwd_en    = 1'b0;
    src_addr  = {5'd0, 5'd3};
    src_valid = 2'b01;
    exe_wb_en = 1'b1;
    exe_dst   = 5'd3;
    #1;
    chk("so_exe_haz", 32'(haz3), 32'd1);
    chk("so_exe_sel", 32'(sel3), 32'd0);
    exe_dst   = 5'd7;
    mem_wb_en = 1'b1;
    mem_dst   = 5'd7;
    #1;
    chk("so_nomatch_haz", 32'(haz3), 32'd0);
    mem_dst = 5'd3;
    #1;
    chk("so_mem_haz", 32'(haz3), 32'd1);

    // forwarding of ALU results
    fwd_en       = 1'b1;
    src_addr     = {5'd5, 5'd4};
    src_valid    = 2'b11;
    exe_dst      = 5'd4;
    mem_dst      = 5'd5;
    exe_mem_r_en = 1'b0;
    #1;
    chk("fw_alu_haz", 32'(haz3), 32'd0);
    chk("fw_alu_sel", 32'(sel3), 32'b1001);
    exe_dst = 5'd5;
    #1;
    chk("fw_prio_sel", 32'(sel3), 32'b0100);
    chk("fw_prio_haz", 32'(haz3), 32'd0);

    // load-use with 3/4/1-cycle stalls, mode toggled mid-stall
    clear_counters();
    load_use_src1(5'd9);
    #1;
    chk("lu_c0_haz3", 32'(haz3), 32'd1);
    chk("lu_c0_sel3", 32'(sel3), 32'b0100);
    chk("lu_c0_hazs", 32'(hazs), 32'd1);
    step();
    idle_inputs();
    fwd_en = 1'b0;
    #1;
    chk("lu_c1_haz3", 32'(haz3), 32'd1);
    chk("lu_c1_hazs", 32'(hazs), 32'd0);
    chk("lu_c1_sel3", 32'(sel3), 32'd0);
    step();
    chk("lu_c2_haz3", 32'(haz3), 32'd1);
    step();
    chk("lu_c3_haz3", 32'(haz3), 32'd0);
    chk("lu_c3_haz4", 32'(haz4), 32'd1);
    chk("lu_cnt3", 32'(cnt3), 32'd3);
    chk("lu_cnts", 32'(cnts), 32'd1);
    step();
    chk("lu_c4_haz4", 32'(haz4), 32'd0);
    chk("lu_cnt4", 32'(cnt4), 32'd4);
    chk("lu_cnt3_hold", 32'(cnt3), 32'd3);

    // flush in the second stall cycle
    clear_counters();
    chk("clr_cnt4", 32'(cnt4), 32'd0);
    load_use_src1(5'd9);
    #1;
    chk("fl_c0_haz4", 32'(haz4), 32'd1);
    step();
    idle_inputs();
    flush = 1'b1;
    #1;
    chk("fl_c1_haz4", 32'(haz4), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_c2_haz4", 32'(haz4), 32'd0);
    chk("fl_cnt4", 32'(cnt4), 32'd1);

    // zero register and invalid sources
    fwd_en       = 1'b1;
    src_addr     = {5'd0, 5'd0};
    src_valid    = 2'b11;
    exe_wb_en    = 1'b1;
    exe_dst      = 5'd0;
    exe_mem_r_en = 1'b1;
    mem_wb_en    = 1'b1;
    mem_dst      = 5'd0;
    #1;
    chk("zr_fw_haz", 32'(haz3), 32'd0);
    chk("zr_fw_sel", 32'(sel3), 32'd0);
    fwd_en = 1'b0;
    #1;
    chk("zr_so_haz", 32'(haz3), 32'd0);
    src_addr  = {5'd6, 5'd6};
    src_valid = 2'b00;
    exe_dst   = 5'd6;
    mem_dst   = 5'd6;
    #1;
    chk("inv_so_haz", 32'(haz3), 32'd0);
    fwd_en = 1'b1;
    #1;
    chk("inv_fw_haz", 32'(haz3), 32'd0);
    chk("inv_fw_sel", 32'(sel3), 32'd0);
    step();
    chk("inv_no_stall", 32'(haz4), 32'd0);

    // counter saturation and clear priority
    clear_counters();
    fwd_en    = 1'b0;
    src_addr  = {5'd0, 5'd3};
    src_valid = 2'b01;
    exe_wb_en = 1'b1;
    exe_dst   = 5'd3;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnts", 32'(cnts), 32'd15);
    chk("sat_cnt3", 32'(cnt3), 32'd20);
    cnt_clr = 1'b1;
    step();
    chk("clrprio_cnts", 32'(cnts), 32'd0);
    chk("clrprio_cnt3", 32'(cnt3), 32'd0);
    cnt_clr = 1'b0;
    step();
    chk("after_clr_cnts", 32'(cnts), 32'd1);

    // asynchronous reset during LU_WAIT
    idle_inputs();
    load_use_src1(5'd12);
    step();
    idle_inputs();
    #1;
    chk("ar_pre_haz4", 32'(haz4), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_haz4", 32'(haz4), 32'd0);
    chk("ar_haz3", 32'(haz3), 32'd0);
    chk("ar_cnt4", 32'(cnt4), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("ar_post_haz4", 32'(haz4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
